// File: rtl/su_pkg.sv
// Shared definitions for the spatial-unrolling psum reducer: FSM encoding,
// default geometry and the signed saturation helper.
package su_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_SEND  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  localparam int unsigned DEF_DATA_BITWIDTH     = 16;
  localparam int unsigned DEF_GBF_DATA_BITWIDTH = 512;
  localparam int unsigned LANES = DEF_GBF_DATA_BITWIDTH / DEF_DATA_BITWIDTH;

  // Accumulator is wide enough for COL full-scale DATA_BITWIDTH operands.
  localparam int unsigned ACC_W = 32;

  function automatic logic signed [ACC_W-1:0] sat_clamp(
    input logic signed [ACC_W-1:0] acc,
    input int unsigned             dw
  );
    logic signed [ACC_W-1:0] hi;
    logic signed [ACC_W-1:0] lo;
    hi = $signed((ACC_W'(1) << (dw - 1)) - ACC_W'(1));
    lo = ~hi;
    if (acc > hi) return hi;
    if (acc < lo) return lo;
    return acc;
  endfunction

endpackage

// File: rtl/su_group_reduce.sv
// Sums one PE row in consecutive groups of irrel_num columns; trailing
// columns that do not fill a group are dropped and unused slots read zero.
module su_group_reduce
  import su_pkg::*;
#(
  parameter int COL           = 16,
  parameter int DATA_BITWIDTH = 16,
  parameter int N_W           = $clog2(COL) + 1
) (
  input  logic [COL*DATA_BITWIDTH-1:0] row,
  input  logic [N_W-1:0]               irrel_num,
  input  logic                         sat_en,
  output logic [COL*DATA_BITWIDTH-1:0] sums
);

  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   clamped;
  logic [DATA_BITWIDTH-1:0]  elem;
  int unsigned               cnt;
  int unsigned               grp;

  always_comb begin
    sums    = '0;
    acc     = '0;
    clamped = '0;
    elem    = '0;
    cnt     = 0;
    grp     = 0;
    for (int unsigned c = 0; c < COL; c++) begin
      elem = row[c*DATA_BITWIDTH +: DATA_BITWIDTH];
      acc  = acc + ACC_W'($signed(elem));
      cnt  = cnt + 1;
      if (cnt == 32'(irrel_num)) begin
        clamped = sat_clamp(acc, DATA_BITWIDTH);
        sums[grp*DATA_BITWIDTH +: DATA_BITWIDTH] =
          sat_en ? clamped[DATA_BITWIDTH-1:0] : acc[DATA_BITWIDTH-1:0];
        grp = grp + 1;
        acc = '0;
        cnt = 0;
      end
    end
  end

endmodule

// File: rtl/su_adder_v2.sv
// Spatial-unrolling psum reducer: snapshots each psum RF entry, reduces column
// groups per row and streams densely packed GBF words with back-pressure.
module su_adder_v2
  import su_pkg::*;
#(
  parameter int ROW                   = 16,
  parameter int COL                   = 16,
  parameter int DATA_BITWIDTH         = DEF_DATA_BITWIDTH,
  parameter int GBF_DATA_BITWIDTH     = DEF_GBF_DATA_BITWIDTH,
  parameter int PSUM_RF_ADDR_BITWIDTH = 2,
  parameter int BRAM_ADDR_BITWIDTH    = 10
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [DATA_BITWIDTH*ROW*COL-1:0]     psum_out,
  input  logic                                 pe_psum_finish,
  input  logic                                 conv_finish,
  input  logic [$clog2(COL):0]                 irrel_num,
  input  logic                                 sat_en,
  input  logic [BRAM_ADDR_BITWIDTH-1:0]        sram_psum_num,
  input  logic                                 out_ready,
  output logic [PSUM_RF_ADDR_BITWIDTH-1:0]     psum_rf_addr,
  output logic                                 su_add_finish,
  output logic [GBF_DATA_BITWIDTH-1:0]         out_data,
  output logic                                 out_valid,
  output logic [BRAM_ADDR_BITWIDTH-1:0]        psum_BRAM_addr,
  output logic                                 cfg_err
);

  localparam int unsigned L      = GBF_DATA_BITWIDTH / DATA_BITWIDTH;
  localparam int unsigned MAX_W  = (ROW*COL + L - 1) / L;
  localparam int unsigned WIDX_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  localparam int unsigned N_W    = $clog2(COL) + 1;
  localparam int unsigned ROW_W  = DATA_BITWIDTH * COL;
  localparam int unsigned PE_W   = DATA_BITWIDTH * ROW * COL;

  logic [2:0]                    state;
  logic [PE_W-1:0]               snapshot;
  logic [PE_W-1:0]               reduce_in;
  logic [PE_W-1:0]               sums;
  logic [N_W-1:0]                n_q;
  logic [N_W-1:0]                g_q;
  logic                          sat_q;
  logic [WIDX_W-1:0]             w_q;
  logic [WIDX_W-1:0]             w_last_q;
  logic [WIDX_W-1:0]             widx;
  logic [BRAM_ADDR_BITWIDTH-1:0] wrap_q;
  logic                          conv_seen;
  logic                          cfg_legal;
  int unsigned                   cfg_groups;
  int unsigned                   cfg_words;
  logic [DATA_BITWIDTH-1:0]      dense [MAX_W*L];
  logic [GBF_DATA_BITWIDTH-1:0]  next_word;

  always_comb begin
    cfg_legal  = (irrel_num != '0) && (32'(irrel_num) <= COL);
    cfg_groups = 1;
    cfg_words  = 1;
    if (cfg_legal) begin
      cfg_groups = COL / 32'(irrel_num);
      cfg_words  = (ROW * cfg_groups + L - 1) / L;
    end
  end

  // The FETCH cycle reduces straight from psum_out so word 0 can be registered
  // on the same edge that captures the snapshot.
  assign reduce_in = (state == S_FETCH) ? psum_out : snapshot;

  for (genvar r = 0; r < ROW; r++) begin : g_row
    su_group_reduce #(
      .COL           (COL),
      .DATA_BITWIDTH (DATA_BITWIDTH),
      .N_W           (N_W)
    ) u_reduce (
      .row       (reduce_in[r*ROW_W +: ROW_W]),
      .irrel_num (n_q),
      .sat_en    (sat_q),
      .sums      (sums[r*ROW_W +: ROW_W])
    );
  end

  always_comb begin
    for (int unsigned i = 0; i < MAX_W*L; i++) dense[i] = '0;
    for (int unsigned r = 0; r < ROW; r++) begin
      for (int unsigned g = 0; g < COL; g++) begin
        if (g < 32'(g_q))
          dense[r*32'(g_q) + g] = sums[(r*COL + g)*DATA_BITWIDTH +: DATA_BITWIDTH];
      end
    end
  end

  assign widx = (state == S_FETCH) ? '0 : w_q + WIDX_W'(1);

  always_comb begin
    next_word = '0;
    for (int unsigned l = 0; l < L; l++)
      next_word[(L-1-l)*DATA_BITWIDTH +: DATA_BITWIDTH] = dense[32'(widx)*L + l];
  end

  assign out_valid     = (state == S_SEND);
  assign su_add_finish = (state == S_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      snapshot       <= '0;
      n_q            <= '0;
      g_q            <= '0;
      sat_q          <= 1'b0;
      w_q            <= '0;
      w_last_q       <= '0;
      wrap_q         <= '0;
      conv_seen      <= 1'b0;
      cfg_err        <= 1'b0;
      psum_rf_addr   <= '0;
      psum_BRAM_addr <= '0;
      out_data       <= '0;
    end else begin
      cfg_err <= 1'b0;
      if (conv_finish && state != S_IDLE) conv_seen <= 1'b1;
      case (state)
        S_IDLE: begin
          if (conv_finish) begin
            state <= S_HALT;
          end else if (pe_psum_finish) begin
            if (cfg_legal) begin
              n_q          <= irrel_num;
              sat_q        <= sat_en;
              g_q          <= N_W'(cfg_groups);
              w_last_q     <= WIDX_W'(cfg_words - 1);
              wrap_q       <= sram_psum_num;
              conv_seen    <= 1'b0;
              psum_rf_addr <= '0;
              state        <= S_FETCH;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        S_FETCH: begin
          snapshot <= psum_out;
          out_data <= next_word;
          w_q      <= '0;
          state    <= S_SEND;
        end
        S_SEND: begin
          if (out_ready) begin
            if (wrap_q != '0 && psum_BRAM_addr >= wrap_q - BRAM_ADDR_BITWIDTH'(1))
              psum_BRAM_addr <= '0;
            else
              psum_BRAM_addr <= psum_BRAM_addr + BRAM_ADDR_BITWIDTH'(1);
            if (w_q == w_last_q) begin
              if (psum_rf_addr == '1) begin
                state <= S_DONE;
              end else begin
                psum_rf_addr <= psum_rf_addr + PSUM_RF_ADDR_BITWIDTH'(1);
                state        <= S_FETCH;
              end
            end else begin
              w_q      <= w_q + WIDX_W'(1);
              out_data <= next_word;
            end
          end
        end
        S_DONE:  state <= (conv_seen || conv_finish) ? S_HALT : S_IDLE;
        S_HALT:  state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_su_adder_v2.sv
// Randomised and directed bench for su_adder_v2 with a scoreboard fed by an
// arithmetic reference model of the group-sum packing.
module tb_su_adder_v2;
  import su_pkg::*;

  localparam int ROW  = 16;
  localparam int COL  = 16;
  localparam int DW   = 16;
  localparam int GBF  = 512;
  localparam int RFW  = 2;
  localparam int BAW  = 10;
  localparam int PE_W = DW * ROW * COL;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [PE_W-1:0]   psum_out;
  logic              pe_psum_finish = 1'b0;
  logic              conv_finish = 1'b0;
  logic [4:0]        irrel_num = 5'd4;
  logic              sat_en = 1'b0;
  logic [BAW-1:0]    sram_psum_num = '0;
  logic              out_ready = 1'b0;
  logic [RFW-1:0]    psum_rf_addr;
  logic              su_add_finish;
  logic [GBF-1:0]    out_data;
  logic              out_valid;
  logic [BAW-1:0]    psum_BRAM_addr;
  logic              cfg_err;

  logic [PE_W-1:0]   pe_mem [4];
  logic [GBF-1:0]    exp_data [$];
  logic [BAW-1:0]    exp_addr [$];
  int                tb_addr = 0;
  int                ready_mode = 1;
  int                n_tests = 0;
  int                n_fail = 0;

  always #5 clk = ~clk;

  assign psum_out = pe_mem[psum_rf_addr];

  su_adder_v2 #(
    .ROW (ROW), .COL (COL), .DATA_BITWIDTH (DW), .GBF_DATA_BITWIDTH (GBF),
    .PSUM_RF_ADDR_BITWIDTH (RFW), .BRAM_ADDR_BITWIDTH (BAW)
  ) dut (
    .clk (clk), .reset_n (reset_n), .psum_out (psum_out),
    .pe_psum_finish (pe_psum_finish), .conv_finish (conv_finish),
    .irrel_num (irrel_num), .sat_en (sat_en), .sram_psum_num (sram_psum_num),
    .out_ready (out_ready), .psum_rf_addr (psum_rf_addr),
    .su_add_finish (su_add_finish), .out_data (out_data), .out_valid (out_valid),
    .psum_BRAM_addr (psum_BRAM_addr), .cfg_err (cfg_err)
  );

  task automatic chk(input string tag, input logic [GBF-1:0] got, input logic [GBF-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      2:       out_ready = ~out_ready;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  initial forever begin
    @(negedge clk);
    if (reset_n && out_valid && out_ready) begin
      if (exp_data.size() == 0) chk("extra_word", 1, 0);
      else begin
        chk("word_data", out_data, exp_data.pop_front());
        chk("word_addr", 512'(psum_BRAM_addr), 512'(exp_addr.pop_front()));
      end
    end
  end

  function automatic logic [DW-1:0] pe_val(input int e, input int r, input int c);
    return pe_mem[e][DW*(r*COL+c) +: DW];
  endfunction

  task automatic build_expected(input int n, input bit sat, input int wrap);
    int g, nres, words, modulus, s, k;
    logic [GBF-1:0] word;
    logic [DW-1:0]  v;
    g = COL / n;
    nres = ROW * g;
    words = (nres + LANES - 1) / LANES;
    modulus = (wrap == 0) ? (1 << BAW) : wrap;
    for (int e = 0; e < 4; e++) begin
      for (int wi = 0; wi < words; wi++) begin
        word = '0;
        for (int l = 0; l < LANES; l++) begin
          k = wi * LANES + l;
          if (k < nres) begin
            s = 0;
            for (int j = 0; j < n; j++) begin
              v = pe_val(e, k / g, (k % g) * n + j);
              s += int'($signed(v));
            end
            if (sat) s = (s > 32767) ? 32767 : (s < -32768) ? -32768 : s;
            word[(LANES-1-l)*DW +: DW] = DW'(s);
          end
        end
        exp_data.push_back(word);
        exp_addr.push_back(BAW'(tb_addr));
        tb_addr = (tb_addr + 1) % modulus;
      end
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 pe_psum_finish = 1'b1;
    @(posedge clk); #1 pe_psum_finish = 1'b0;
  endtask

  task automatic run_pass(input int n, input bit sat, input int wrap, input int mode, input int conv_at);
    int cyc;
    irrel_num = 5'(n);
    sat_en = sat;
    sram_psum_num = BAW'(wrap);
    ready_mode = mode;
    build_expected(n, sat, wrap);
    pulse_start();
    if (conv_at > 0) begin
      repeat (conv_at) @(posedge clk);
      #1 conv_finish = 1'b1;
      @(posedge clk); #1 conv_finish = 1'b0;
    end
    cyc = 0;
    if (conv_at > 0) begin
      while (exp_data.size() != 0 && cyc < 5000) begin @(negedge clk); cyc++; end
      repeat (3) @(negedge clk);
      chk("halt_finish", 512'(su_add_finish), 0);
      chk("halt_valid", 512'(out_valid), 0);
    end else begin
      while (!su_add_finish && cyc < 5000) begin @(negedge clk); cyc++; end
      chk("pass_done", 512'(su_add_finish), 1);
    end
    chk("words_left", 512'(exp_data.size()), 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    exp_data.delete();
    exp_addr.delete();
    tb_addr = 0;
  endtask

  task automatic fill_const(input logic [DW-1:0] v);
    for (int e = 0; e < 4; e++)
      for (int i = 0; i < ROW*COL; i++) pe_mem[e][i*DW +: DW] = v;
  endtask

  task automatic fill_random();
    for (int e = 0; e < 4; e++)
      for (int i = 0; i < PE_W/32; i++) pe_mem[e][i*32 +: 32] = $urandom();
  endtask

  initial begin
    int cnt;
    fill_const(16'd1);
    do_reset();
    @(negedge clk);
    chk("rst_rf_addr", 512'(psum_rf_addr), 0);
    chk("rst_bram_addr", 512'(psum_BRAM_addr), 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_valid", 512'(out_valid), 0);
    chk("rst_finish", 512'(su_add_finish), 1);
    chk("rst_cfg_err", 512'(cfg_err), 0);

    run_pass(4, 1'b0, 0, 1, 0);
    chk("bram_after_g4", 512'(psum_BRAM_addr), 8);
    run_pass(3, 1'b0, 0, 1, 0);
    for (int e = 0; e < 4; e++)
      for (int r = 0; r < ROW; r++)
        for (int c = 0; c < COL; c++) pe_mem[e][DW*(r*COL+c) +: DW] = DW'(r*16 + c + e*256);
    run_pass(1, 1'b0, 0, 2, 0);
    fill_const(16'h7FFF);
    run_pass(16, 1'b1, 0, 1, 0);
    run_pass(16, 1'b0, 0, 3, 0);

    do_reset();
    fill_random();
    run_pass(8, 1'b0, 5, 1, 0);
    run_pass(8, 1'b1, 5, 1, 0);
    chk("bram_wrap", 512'(psum_BRAM_addr), 3);

    for (int t = 0; t < 2; t++) begin
      irrel_num = (t == 0) ? 5'd0 : 5'd17;
      ready_mode = 1;
      pulse_start();
      @(negedge clk);
      chk("cfg_err_pulse", 512'(cfg_err), 1);
      cnt = 0;
      repeat (6) begin @(negedge clk); if (out_valid || cfg_err) cnt++; end
      chk("cfg_err_quiet", 512'(cnt), 0);
      chk("cfg_err_idle", 512'(su_add_finish), 1);
    end

    sram_psum_num = '0;
    for (int t = 0; t < 6; t++) begin
      fill_random();
      run_pass(int'($urandom_range(1, COL)), 1'($urandom_range(0, 1)), 0, 3, 0);
    end

    fill_random();
    run_pass(8, 1'b0, 0, 1, 3);
    irrel_num = 5'd4;
    pulse_start();
    cnt = 0;
    repeat (6) begin @(negedge clk); if (out_valid) cnt++; end
    chk("halt_ignores_start", 512'(cnt), 0);
    chk("halt_sticky", 512'(su_add_finish), 0);

    do_reset();
    fill_random();
    irrel_num = 5'd2;
    sat_en = 1'b0;
    build_expected(2, 1'b0, 0);
    ready_mode = 3;
    pulse_start();
    cnt = 0;
    while (!(psum_rf_addr == 2'd2 && out_valid) && cnt < 500) begin @(negedge clk); cnt++; end
    chk("reach_send", 512'(out_valid), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("amid_valid", 512'(out_valid), 0);
    chk("amid_rf_addr", 512'(psum_rf_addr), 0);
    chk("amid_bram_addr", 512'(psum_BRAM_addr), 0);
    chk("amid_finish", 512'(su_add_finish), 1);
    @(posedge clk); #1 reset_n = 1'b1;
    exp_data.delete();
    exp_addr.delete();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
